// File: rtl/band_mixer.sv
// band_mixer: collects one sample from each of three band filters, applies a signed
// Q2.14 gain per band through a single time-shared registered multiplier, then sums,
// saturates and emits one mixed sample per frame.
module band_mixer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned GAIN_FRAC = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] band0_sample,
    input  logic             band0_valid,
    input  logic [WIDTH-1:0] band1_sample,
    input  logic             band1_valid,
    input  logic [WIDTH-1:0] band2_sample,
    input  logic             band2_valid,
    input  logic [15:0]      gain0,
    input  logic [15:0]      gain1,
    input  logic [15:0]      gain2,
    output logic [WIDTH-1:0] mixed_sample,
    output logic             mixed_valid,
    output logic             clip,
    output logic             overrun
);

    localparam int unsigned ProdW = WIDTH + 16;
    // Two guard bits: three full-scale products cannot overflow the accumulator.
    localparam int unsigned AccW  = ProdW + 2;

    localparam logic signed [AccW-1:0] SatMax = {{(AccW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin = {{(AccW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StWait, StMul0, StMul1, StMul2, StSum, StOut} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                pend_q, pend_d;
    logic [2:0]                valids;
    logic                      leave;
    logic                      overrun_q, overrun_d;
    logic [WIDTH-1:0]          slot0_q, slot1_q, slot2_q;
    logic [WIDTH-1:0]          work1_q, work2_q;
    logic [WIDTH-1:0]          op_a_q;
    logic [15:0]               op_b_q;
    logic signed [ProdW-1:0]   prod_q;
    logic signed [AccW-1:0]    acc_q;
    logic signed [AccW-1:0]    prod_ext;
    logic signed [AccW-1:0]    shifted;
    logic [WIDTH-1:0]          sat_d;
    logic                      clip_d;
    logic [WIDTH-1:0]          mixed_sample_q;
    logic                      mixed_valid_q, clip_q;

    // Next-state, pending-flag and overrun decode.
    always_comb begin
        valids    = {band2_valid, band1_valid, band0_valid};
        leave     = (state_q == StWait) && (pend_q == 3'b111);
        // A strobe on the leaving edge belongs to the next frame and is not an overrun.
        pend_d    = leave ? valids : (pend_q | valids);
        overrun_d = !leave && |(valids & pend_q);
        state_d   = state_q;
        unique case (state_q)
            StWait:  if (leave) state_d = StMul0;
            StMul0:  state_d = StMul1;
            StMul1:  state_d = StMul2;
            StMul2:  state_d = StSum;
            StSum:   state_d = StOut;
            StOut:   state_d = StWait;
            default: state_d = StWait;
        endcase
    end

    // Scale the accumulator back to sample units and clamp to the sample range.
    always_comb begin
        prod_ext = {{2{prod_q[ProdW-1]}}, prod_q};
        shifted  = acc_q >>> GAIN_FRAC;
        sat_d    = shifted[WIDTH-1:0];
        clip_d   = 1'b0;
        if (shifted > SatMax) begin
            sat_d  = SatMax[WIDTH-1:0];
            clip_d = 1'b1;
        end else if (shifted < SatMin) begin
            sat_d  = SatMin[WIDTH-1:0];
            clip_d = 1'b1;
        end
    end

    // Control state and band capture slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StWait;
            pend_q    <= '0;
            overrun_q <= 1'b0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            slot2_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            if (band0_valid) slot0_q <= band0_sample;
            if (band1_valid) slot1_q <= band1_sample;
            if (band2_valid) slot2_q <= band2_sample;
        end
    end

    // Shared multiplier pipeline, accumulator and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work1_q        <= '0;
            work2_q        <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            prod_q         <= '0;
            acc_q          <= '0;
            mixed_sample_q <= '0;
            mixed_valid_q  <= 1'b0;
            clip_q         <= 1'b0;
        end else begin
            prod_q        <= $signed(op_a_q) * $signed(op_b_q);
            mixed_valid_q <= 1'b0;
            clip_q        <= 1'b0;
            unique case (state_q)
                StWait: begin
                    if (leave) begin
                        // Snapshot so new strobes during the frame cannot corrupt it.
                        work1_q <= slot1_q;
                        work2_q <= slot2_q;
                        op_a_q  <= slot0_q;
                        op_b_q  <= gain0;
                        acc_q   <= '0;
                    end
                end
                StMul0: begin
                    op_a_q <= work1_q;
                    op_b_q <= gain1;
                end
                StMul1: begin
                    op_a_q <= work2_q;
                    op_b_q <= gain2;
                    acc_q  <= acc_q + prod_ext;
                end
                StMul2, StSum: acc_q <= acc_q + prod_ext;
                StOut: begin
                    mixed_sample_q <= sat_d;
                    clip_q         <= clip_d;
                    mixed_valid_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mixed_sample = mixed_sample_q;
    assign mixed_valid  = mixed_valid_q;
    assign clip         = clip_q;
    assign overrun      = overrun_q;

endmodule
